// File: rtl/gen_sched_pkg.sv
// rtl/gen_sched_pkg.sv - shared types and constants for the generator job scheduler
//
// Purpose: FSM state encoding, the default job record layout and the width of
// the completed-job counter. No ports (package).

package gen_sched_pkg;

  localparam int DONE_CNT_W = 16;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_TAG_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN
  } state_t;

  // Default job record. The scheduler builds an equivalent record sized by its
  // own WIDTH/TAG_W parameters and hands it to the FIFO as a type parameter.
  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] arg0;
    logic signed [DEF_WIDTH-1:0] arg1;
    logic signed [DEF_WIDTH-1:0] arg2;
    logic [DEF_TAG_W-1:0]        tag;
  } job_t;

endpackage

// File: rtl/gen_job_fifo.sv
// rtl/gen_job_fifo.sv - synchronous job FIFO with registered occupancy count
//
// Purpose: holds queued jobs in arrival order for the scheduler.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (empties the queue)
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   job record to enqueue
//   pop        in   drop the head entry (ignored when empty)
//   head       out  current head entry (valid only when count != 0)
//   count      out  number of stored entries, 0..DEPTH

module gen_job_fifo
  import gen_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = job_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  T              mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count < FULL);
  assign do_pop  = pop && (count != '0);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/gen_job_scheduler.sv
// rtl/gen_job_scheduler.sv - queues argument triples and runs a shared generator once per job
//
// Purpose: accepts jobs into a DEPTH-entry queue, launches the generator for
// each in order, forwards its output beats downstream tagged with the job ID,
// and counts completed jobs.
// Ports:
//   _clock, _reset             clock; async active-high reset (shared with generator)
//   job_valid/job_ready        job offer handshake; job_arg0..2 argument triple
//   gen_start, gen_arg0..2     one-cycle launch pulse and arguments to the generator
//   gen_ready                  generator output ready (mirrors downstream _ready in RUN)
//   gen_valid, gen_done        generator beat valid and end-of-job indication
//   gen_out0/1                 generator data
//   _ready/_valid, _out0/1     downstream beat handshake and data
//   _out_tag                   tag of the job producing the current beat
//   _done                      idle with an empty queue
//   jobs_completed             wrapping count of finished jobs

module gen_job_scheduler
  import gen_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic signed [WIDTH-1:0] job_arg0,
  input  logic signed [WIDTH-1:0] job_arg1,
  input  logic signed [WIDTH-1:0] job_arg2,
  output logic                    gen_start,
  output logic signed [WIDTH-1:0] gen_arg0,
  output logic signed [WIDTH-1:0] gen_arg1,
  output logic signed [WIDTH-1:0] gen_arg2,
  output logic                    gen_ready,
  input  logic                    gen_valid,
  input  logic                    gen_done,
  input  logic signed [WIDTH-1:0] gen_out0,
  input  logic signed [WIDTH-1:0] gen_out1,
  input  logic                    _ready,
  output logic                    _valid,
  output logic signed [WIDTH-1:0] _out0,
  output logic signed [WIDTH-1:0] _out1,
  output logic [TAG_W-1:0]        _out_tag,
  output logic                    _done,
  output logic [DONE_CNT_W-1:0]   jobs_completed
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic signed [WIDTH-1:0] arg0;
    logic signed [WIDTH-1:0] arg1;
    logic signed [WIDTH-1:0] arg2;
    logic [TAG_W-1:0]        tag;
  } sched_job_t;

  state_t          state;
  state_t          state_next;
  sched_job_t      push_job;
  sched_job_t      head_job;
  logic [CW-1:0]   q_count;
  logic            push;
  logic            pop;
  logic [TAG_W-1:0] next_tag;
  logic [TAG_W-1:0] cur_tag;
  logic            job_finish;

  // Full is judged on the registered count only, so a pop in the same cycle
  // cannot open the queue early.
  assign job_ready = (q_count < FULL);
  assign push      = job_valid && job_ready;
  assign pop       = (state == LAUNCH);

  assign push_job.arg0 = job_arg0;
  assign push_job.arg1 = job_arg1;
  assign push_job.arg2 = job_arg2;
  assign push_job.tag  = next_tag;

  gen_job_fifo #(
    .DEPTH (DEPTH),
    .T     (sched_job_t)
  ) u_fifo (
    .clk       (_clock),
    .rst       (_reset),
    .push      (push),
    .push_data (push_job),
    .pop       (pop),
    .head      (head_job),
    .count     (q_count)
  );

  // Arguments come straight from the head; they only matter while gen_start is high.
  assign gen_arg0 = head_job.arg0;
  assign gen_arg1 = head_job.arg1;
  assign gen_arg2 = head_job.arg2;

  // Data is a pure pass-through; _valid qualifies it.
  assign _out0    = gen_out0;
  assign _out1    = gen_out1;
  assign _out_tag = cur_tag;

  assign job_finish = (state == RUN) && gen_done && gen_ready;

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state          <= IDLE;
      next_tag       <= '0;
      cur_tag        <= '0;
      jobs_completed <= '0;
    end else begin
      state <= state_next;
      if (push)       next_tag       <= next_tag + 1'b1;
      if (pop)        cur_tag        <= head_job.tag;
      if (job_finish) jobs_completed <= jobs_completed + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    gen_start  = 1'b0;
    gen_ready  = 1'b0;
    _valid     = 1'b0;
    _done      = 1'b0;
    case (state)
      IDLE: begin
        _done = (q_count == '0);
        if (q_count != '0) state_next = LAUNCH;
      end
      LAUNCH: begin
        gen_start  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        // Downstream back-pressure stalls the generator directly.
        gen_ready = _ready;
        _valid    = gen_valid;
        // A job pushed this very cycle is not yet in q_count, so it waits for IDLE.
        if (gen_done && _ready) state_next = (q_count != '0) ? LAUNCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gen_job_scheduler.sv
// tb/tb_gen_job_scheduler.sv - scoreboard bench for gen_job_scheduler with a behavioural generator

module tb_gen_job_scheduler;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic job_valid, job_ready;
  logic signed [WIDTH-1:0] job_arg0, job_arg1, job_arg2;
  logic gen_start, gen_ready, gen_valid, gen_done;
  logic signed [WIDTH-1:0] gen_arg0, gen_arg1, gen_arg2, gen_out0, gen_out1;
  logic out_ready, out_valid, done_o;
  logic signed [WIDTH-1:0] out0, out1;
  logic [TAG_W-1:0] out_tag;
  logic [15:0] jobs_completed;

  gen_job_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    ._clock(clk), ._reset(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_arg0(job_arg0), .job_arg1(job_arg1), .job_arg2(job_arg2),
    .gen_start(gen_start), .gen_arg0(gen_arg0), .gen_arg1(gen_arg1), .gen_arg2(gen_arg2),
    .gen_ready(gen_ready), .gen_valid(gen_valid), .gen_done(gen_done),
    .gen_out0(gen_out0), .gen_out1(gen_out1),
    ._ready(out_ready), ._valid(out_valid), ._out0(out0), ._out1(out1),
    ._out_tag(out_tag), ._done(done_o), .jobs_completed(jobs_completed)
  );

  always #5 clk = ~clk;

  typedef struct { longint o0; longint o1; int tag; bit last; } beat_t;
  typedef struct { longint a0; longint a1; longint a2; } launch_t;

  beat_t   exp_q[$];
  launch_t launch_q[$];

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint accept_cyc = 0;
  longint launch_cyc = 0;
  longint last_done_cyc = -1;
  int     launches = 0;
  int     beat_cnt = 0;
  int     next_tag = 0;
  int     exp_completed = 0;
  bit     gap_check_en = 0;
  bit     prev_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string act, input string exp);
    checks++;
    errors++;
    $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  // Behavioural generator: a job (a0,a1,n) emits n beats {a0+k, a1-k}, with
  // done raised alongside the last beat.
  longint g_a0, g_a1, g_n, g_k;
  bit     g_busy = 0;
  initial begin
    bit s_rst, s_start, s_ready;
    longint s_a0, s_a1, s_a2;
    gen_valid = 0; gen_done = 0; gen_out0 = 0; gen_out1 = 0;
    g_a0 = 0; g_a1 = 0; g_n = 1; g_k = 0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_start = gen_start; s_ready = gen_ready;
      s_a0 = gen_arg0; s_a1 = gen_arg1; s_a2 = gen_arg2;
      #1;
      if (s_rst || rst) g_busy = 0;
      else begin
        if (g_busy && s_ready) begin
          if (g_k == g_n - 1) g_busy = 0;
          else g_k++;
        end
        if (s_start) begin
          g_busy = 1; g_k = 0; g_a0 = s_a0; g_a1 = s_a1; g_n = s_a2;
        end
      end
      gen_valid = g_busy;
      gen_done  = g_busy && (g_k == g_n - 1);
      gen_out0  = g_busy ? WIDTH'(g_a0 + g_k) : '0;
      gen_out1  = g_busy ? WIDTH'(g_a1 - g_k) : '0;
    end
  end

  // Monitor: checks launches and downstream beats against the scoreboard.
  initial begin
    beat_t   b;
    launch_t l;
    forever begin
      @(negedge clk);
      if (gen_start) begin
        chk("start_pulse_width", prev_start, 0);
        if (launch_q.size() == 0) fail_now("unexpected_launch", "launch", "none");
        else begin
          l = launch_q.pop_front();
          chk("launch_arg0", gen_arg0, l.a0);
          chk("launch_arg1", gen_arg1, l.a1);
          chk("launch_arg2", gen_arg2, l.a2);
        end
        if (gap_check_en && last_done_cyc >= 0) chk("launch_gap", cyc - last_done_cyc, 1);
        launch_cyc = cyc;
        launches++;
      end
      prev_start = gen_start;
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) fail_now("unexpected_beat", "beat", "none");
        else begin
          b = exp_q.pop_front();
          chk("beat_out0", out0, b.o0);
          chk("beat_out1", out1, b.o1);
          chk("beat_tag", out_tag, b.tag);
          chk("beat_jobs_completed", jobs_completed, exp_completed);
          if (b.last) begin
            exp_completed++;
            last_done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic send_job(input longint a0, input longint a1, input longint a2);
    int waited = 0;
    bit acc = 0;
    job_arg0 = WIDTH'(a0); job_arg1 = WIDTH'(a1); job_arg2 = WIDTH'(a2);
    job_valid = 1;
    while (!acc && waited < 400) begin
      @(posedge clk);
      if (job_ready) acc = 1;
      else waited++;
    end
    if (!acc) fail_now("job_accept_timeout", "not accepted", "accepted");
    else begin
      accept_cyc = cyc;
      launch_q.push_back('{a0: a0, a1: a1, a2: a2});
      for (longint k = 0; k < a2; k++)
        exp_q.push_back('{o0: a0 + k, o1: a1 - k, tag: next_tag % (1 << TAG_W), last: (k == a2 - 1)});
      next_tag++;
    end
    #1 job_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done_o && exp_q.size() == 0 && launch_q.size() == 0) && n < 3000);
    if (n >= 3000) fail_now(name, "busy", "idle");
  endtask

  task automatic wait_launch(input int target);
    int n = 0;
    while (launches < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (launches < target) fail_now("launch_timeout", "no launch", "launch");
  endtask

  initial begin
    int n;
    int start_beats;
    logic signed [WIDTH-1:0] held0, held1;
    rst = 1; job_valid = 0; out_ready = 1;
    job_arg0 = '0; job_arg1 = '0; job_arg2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_gen_start", gen_start, 0);
    chk("reset_gen_ready", gen_ready, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_job_ready", job_ready, 1);
    chk("reset_done", done_o, 1);
    chk("reset_jobs_completed", jobs_completed, 0);
    rst = 0;
    @(posedge clk); #1;

    // Single job: launch latency and completion.
    n = launches;
    send_job(50, 50, 8);
    wait_launch(n + 1);
    chk("first_launch_latency", launch_cyc - accept_cyc, 2);
    wait_idle("single_job_timeout");
    chk("single_done", done_o, 1);
    chk("single_jobs_completed", jobs_completed, 1);

    // Three queued jobs: one LAUNCH cycle between consecutive jobs.
    last_done_cyc = -1;
    gap_check_en = 1;
    send_job(54, 52, 8);
    send_job(46, 52, 8);
    send_job(50, 48, 8);
    wait_idle("three_jobs_timeout");
    gap_check_en = 0;
    chk("three_jobs_completed", jobs_completed, 4);

    // Queue full while the generator is busy.
    n = launches;
    send_job(1000, 0, 20);
    wait_launch(n + 1);
    send_job(1, 2, 3);
    send_job(3, 4, 3);
    send_job(5, 6, 3);
    send_job(7, 8, 3);
    @(negedge clk);
    chk("full_job_ready", job_ready, 0);
    chk("full_still_one_launch", launches, n + 1);
    send_job(9, 10, 3);
    wait_idle("full_queue_timeout");
    chk("full_jobs_completed", jobs_completed, 10);

    // Downstream back-pressure for 5 cycles mid-run.
    start_beats = beat_cnt;
    send_job(100, 200, 10);
    n = 0;
    while (beat_cnt < start_beats + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (beat_cnt < start_beats + 3) fail_now("backpressure_start_timeout", "no beats", "3 beats");
    @(posedge clk); #1 out_ready = 0;
    held0 = '0; held1 = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_gen_ready", gen_ready, 0);
      chk("stall_valid", out_valid, 1);
      if (i == 0) begin
        held0 = out0;
        held1 = out1;
      end else begin
        chk("stall_out0_stable", out0, held0);
        chk("stall_out1_stable", out1, held1);
      end
    end
    @(posedge clk); #1 out_ready = 1;
    wait_idle("backpressure_timeout");
    chk("backpressure_beats", beat_cnt - start_beats, 10);
    chk("backpressure_jobs_completed", jobs_completed, 11);

    // Reset mid-run with two jobs queued.
    n = launches;
    send_job(-500, 7, 30);
    wait_launch(n + 1);
    send_job(11, 12, 4);
    send_job(13, 14, 4);
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    rst = 1;
    exp_q.delete();
    launch_q.delete();
    next_tag = 0;
    exp_completed = 0;
    #1;
    chk("midreset_gen_start", gen_start, 0);
    chk("midreset_valid", out_valid, 0);
    chk("midreset_done", done_o, 1);
    chk("midreset_job_ready", job_ready, 1);
    chk("midreset_jobs_completed", jobs_completed, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    n = beat_cnt;
    repeat (40) @(negedge clk);
    chk("post_reset_beats", beat_cnt - n, 0);
    chk("post_reset_jobs_completed", jobs_completed, 0);
    chk("post_reset_done", done_o, 1);

    // Tag wrap with a 2-bit tag: 0,1,2,3,0.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      send_job(i * 10, -i * 5, 2);
      wait_idle("tag_wrap_timeout");
    end
    chk("tag_wrap_jobs_completed", jobs_completed, 5);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
